// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for inst_queue.
// master = fetch/decode side, slave = the queue itself.
interface inst_queue_if #(
  parameter int AW = 1
);
  logic          IF_over;
  logic [64:0]   IF_ID_bus;
  logic          flush;
  logic          ID_allow;
  logic          IF_allow;
  logic          ID_valid;
  logic [64:0]   ID_bus;
  logic [AW:0]   q_count;

  modport master (
    output IF_over, IF_ID_bus, flush, ID_allow,
    input  IF_allow, ID_valid, ID_bus, q_count
  );

  modport slave (
    input  IF_over, IF_ID_bus, flush, ID_allow,
    output IF_allow, ID_valid, ID_bus, q_count
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of {pc, inst, fetch_error}.
// Optional macro INSTQ_BYPASS_EN: an empty queue forwards the fetch bundle to decode in the same cycle.
module inst_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  qif
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, push, pop, wr_en, rd_en;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign qif.IF_allow = ~full;
  assign qif.q_count  = count_q;
  assign push         = qif.IF_over & ~full & ~qif.flush;

`ifdef INSTQ_BYPASS_EN
  logic bypass;
  assign bypass       = empty & qif.IF_over & ~qif.flush;
  assign qif.ID_valid = (~empty | qif.IF_over) & ~qif.flush;
  assign qif.ID_bus   = empty ? (qif.IF_over ? qif.IF_ID_bus : '0) : mem[rd_ptr_q];
  // A bypassed bundle taken by decode never touches storage.
  assign wr_en        = push & ~(bypass & qif.ID_allow);
`else
  assign qif.ID_valid = ~empty & ~qif.flush;
  assign qif.ID_bus   = empty ? '0 : mem[rd_ptr_q];
  assign wr_en        = push;
`endif

  assign pop   = qif.ID_valid & qif.ID_allow & ~qif.flush;
  assign rd_en = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (qif.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; unread entries are masked by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= qif.IF_ID_bus;
  end
endmodule
